dyn_mem_bank_group_ctrl: RTL

TCDM responder that terminates one bank-group port of the dynamic-SPM crossbar. It splits each bank-group access across NUM_BANK single-port SRAM macros and returns a response with fixed 1-cycle latency. It also power-gates the group: it sleeps after an idle timeout and wakes on demand, holding gnt low while waking.

---
 rtl/dyn_mem_pkg.sv | 10 +
 rtl/dyn_mem_bank_pwr_ctrl.sv | 93 +++++++++
 rtl/dyn_mem_bank_group_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/dyn_mem_pkg.sv
// Shared types and helpers for the dynamic-SPM bank-group responder.
package dyn_mem_pkg;

  typedef enum logic [1:0] {SLEEP = 2'd0, WAKE = 2'd1, ACTIVE = 2'd2} bkgp_pwr_state_e;

  function automatic int bank_data_width(input int group_w, input int num_bank);
    return group_w / num_bank;
  endfunction

endpackage

// File: rtl/dyn_mem_bank_pwr_ctrl.sv
// Power-gating FSM for one bank group: sleeps after an idle timeout, wakes on demand
// and only enables grants once the macros have had WAKE_CYCLES to settle.
module dyn_mem_bank_pwr_ctrl
  import dyn_mem_pkg::*;
#(
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic sleep_en,
  output logic pwr_en,
  output logic awake,
  output logic gnt_en
);

  localparam int WakeW = $clog2(WAKE_CYCLES + 1);
  localparam int IdleW = $clog2(IDLE_CYCLES + 1);
  localparam logic [WakeW-1:0] WakeLoad = WakeW'(WAKE_CYCLES - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IDLE_CYCLES);

  bkgp_pwr_state_e  state_r, state_s;
  logic [WakeW-1:0] wake_cnt_r, wake_cnt_s;
  logic [IdleW-1:0] idle_cnt_r, idle_cnt_s, idle_inc_s;
  logic             pwr_en_s, awake_s;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SLEEP;
      wake_cnt_r <= '0;
      idle_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      wake_cnt_r <= wake_cnt_s;
      idle_cnt_r <= idle_cnt_s;
    end
  end

  // Next-state, counter update and power outputs
  always_comb begin
    state_s    = state_r;
    wake_cnt_s = wake_cnt_r;
    idle_cnt_s = idle_cnt_r;
    pwr_en_s   = 1'b0;
    awake_s    = 1'b0;
    idle_inc_s = (idle_cnt_r == IdleMax) ? idle_cnt_r : idle_cnt_r + IdleW'(1);
    case (state_r)
      SLEEP: begin
        idle_cnt_s = '0;
        if (req) begin
          state_s    = WAKE;
          wake_cnt_s = WakeLoad;
        end else begin
          state_s    = SLEEP;
        end
      end
      WAKE: begin
        pwr_en_s = 1'b1;
        if (wake_cnt_r == '0) begin
          state_s    = ACTIVE;
          idle_cnt_s = '0;
        end else begin
          wake_cnt_s = wake_cnt_r - WakeW'(1);
        end
      end
      ACTIVE: begin
        pwr_en_s = 1'b1;
        awake_s  = 1'b1;
        // A request in the timeout cycle wins over going to sleep.
        if (req || !sleep_en) begin
          idle_cnt_s = '0;
        end else if (idle_inc_s == IdleMax) begin
          state_s    = SLEEP;
          idle_cnt_s = '0;
        end else begin
          idle_cnt_s = idle_inc_s;
        end
      end
      default: begin
        state_s    = SLEEP;
        wake_cnt_s = '0;
        idle_cnt_s = '0;
      end
    endcase
  end

  assign pwr_en = pwr_en_s;
  assign awake  = awake_s;
  assign gnt_en = awake_s;

endmodule

// File: rtl/dyn_mem_bank_group_ctrl.sv
// TCDM responder for one bank group: fans each access out to NUM_BANK SRAM slices
// and returns a response with fixed 1-cycle latency; power is managed by the pwr_ctrl.
module dyn_mem_bank_group_ctrl
  import dyn_mem_pkg::*;
#(
  parameter int NUM_BANK                     = 2,
  parameter int BANK_GROUP_DATA_WIDTH        = 64,
  parameter int BANK_LEVEL_EFFECT_ADDR_WIDTH = 10,
  parameter int WAKE_CYCLES                  = 4,
  parameter int IDLE_CYCLES                  = 16,
  localparam int BankDataWidth = bank_data_width(BANK_GROUP_DATA_WIDTH, NUM_BANK),
  localparam int BankBeWidth   = BankDataWidth / 8
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic [BANK_GROUP_DATA_WIDTH-1:0]                       tcdm_wdata_i,
  input  logic [BANK_LEVEL_EFFECT_ADDR_WIDTH-1:0]                tcdm_addr_i,
  input  logic                                                   tcdm_we_i,
  input  logic [BANK_GROUP_DATA_WIDTH/8-1:0]                     tcdm_strb_i,
  input  logic                                                   tcdm_req_i,
  output logic                                                   tcdm_gnt_o,
  output logic                                                   tcdm_rvalid_o,
  output logic [BANK_GROUP_DATA_WIDTH-1:0]                       tcdm_rdata_o,
  output logic [NUM_BANK-1:0]                                    sram_req_o,
  output logic [NUM_BANK-1:0]                                    sram_we_o,
  output logic [NUM_BANK-1:0][BANK_LEVEL_EFFECT_ADDR_WIDTH-1:0]  sram_addr_o,
  output logic [NUM_BANK-1:0][BankDataWidth-1:0]                 sram_wdata_o,
  output logic [NUM_BANK-1:0][BankBeWidth-1:0]                   sram_be_o,
  input  logic [NUM_BANK-1:0][BankDataWidth-1:0]                 sram_rdata_i,
  output logic                                                   sram_pwr_en_o,
  input  logic                                                   sleep_en_i,
  output logic                                                   awake_o
);

  logic                             gnt_en_s;
  logic                             accept_s;
  logic                             rvalid_r;
  logic                             rd_r;
  logic [BANK_GROUP_DATA_WIDTH-1:0] rdata_s;

  dyn_mem_bank_pwr_ctrl #(
    .WAKE_CYCLES (WAKE_CYCLES),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_pwr_ctrl (
    .clk      (clk_i),
    .rst      (rst_i),
    .req      (tcdm_req_i),
    .sleep_en (sleep_en_i),
    .pwr_en   (sram_pwr_en_o),
    .awake    (awake_o),
    .gnt_en   (gnt_en_s)
  );

  assign tcdm_gnt_o = gnt_en_s;
  assign accept_s   = tcdm_req_i & gnt_en_s;
  assign sram_req_o = {NUM_BANK{accept_s}};
  assign sram_we_o  = {NUM_BANK{tcdm_we_i}};

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign sram_addr_o[b]  = tcdm_addr_i;
    assign sram_wdata_o[b] = tcdm_wdata_i[b*BankDataWidth +: BankDataWidth];
    assign sram_be_o[b]    = tcdm_strb_i[b*BankBeWidth +: BankBeWidth];
  end

  // Response tracking: one rvalid per accept, remembering whether it was a read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      rd_r     <= 1'b0;
    end else begin
      rvalid_r <= accept_s;
      rd_r     <= accept_s & ~tcdm_we_i;
    end
  end

  // SRAM data arrives in the response cycle; bank 0 lands in the LSBs
  always_comb begin
    rdata_s = '0;
    if (rvalid_r && rd_r) begin
      rdata_s = sram_rdata_i;
    end else begin
      rdata_s = '0;
    end
  end

  assign tcdm_rvalid_o = rvalid_r;
  assign tcdm_rdata_o  = rdata_s;

endmodule
